// File: rtl/ibus_arbiter2.sv
// Two-master arbiter onto a single registered slave bus, with bounded-burst fairness.
// Read returns are routed back to the issuing master through a tag pipeline matched to RD_LAT.
module ibus_arbiter2 #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BURST  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_adr,
  input  logic [15:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_adr,
  input  logic [15:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [15:0] m0_rdata,
  output logic [15:0] m1_rdata,
  output logic        ren,
  output logic        wen,
  output logic [15:0] ibus_radr,
  output logic [15:0] ibus_wadr,
  output logic [15:0] ibus_wdata,
  input  logic [15:0] ibus_rdata
);

  localparam logic [3:0] BurstLim = 4'(BURST);

  logic        r_owner;
  logic [3:0]  r_cnt;
  logic        r_ren;
  logic        r_wen;
  logic [15:0] r_radr;
  logic [15:0] r_wadr;
  logic [15:0] r_wdata;
  // Stage 0 is loaded alongside ren; stage RD_LAT lines up with ibus_rdata.
  logic [RD_LAT:0] r_tag_v;
  logic [RD_LAT:0] r_tag_id;

  logic        w_xfer;
  logic        w_sel;
  logic        w_we;
  logic [15:0] w_adr;
  logic [15:0] w_wdata;

  always_comb begin
    w_sel = 1'b0;
    case ({m1_req, m0_req})
      2'b01:   w_sel = 1'b0;
      2'b10:   w_sel = 1'b1;
      2'b11:   w_sel = (r_cnt < BurstLim) ? r_owner : ~r_owner;
      default: w_sel = 1'b0;
    endcase
  end

  assign w_xfer  = m0_req | m1_req;
  assign m0_gnt  = w_xfer & ~w_sel;
  assign m1_gnt  = w_xfer & w_sel;
  assign w_we    = w_sel ? m1_we    : m0_we;
  assign w_adr   = w_sel ? m1_adr   : m0_adr;
  assign w_wdata = w_sel ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= 1'b0;
      r_cnt   <= 4'd0;
    end else if (w_xfer) begin
      if (w_sel == r_owner) begin
        if (r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
      end else begin
        r_owner <= w_sel;
        r_cnt   <= 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_radr  <= 16'h0000;
      r_wadr  <= 16'h0000;
      r_wdata <= 16'h0000;
    end else begin
      r_ren <= w_xfer & ~w_we;
      r_wen <= w_xfer & w_we;
      if (w_xfer && !w_we) r_radr <= w_adr;
      if (w_xfer && w_we) begin
        r_wadr  <= w_adr;
        r_wdata <= w_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v  <= {r_tag_v[RD_LAT-1:0], w_xfer & ~w_we};
      r_tag_id <= {r_tag_id[RD_LAT-1:0], w_sel};
    end
  end

  assign ren        = r_ren;
  assign wen        = r_wen;
  assign ibus_radr  = r_radr;
  assign ibus_wadr  = r_wadr;
  assign ibus_wdata = r_wdata;
  assign m0_rvalid  = r_tag_v[RD_LAT] & ~r_tag_id[RD_LAT];
  assign m1_rvalid  = r_tag_v[RD_LAT] & r_tag_id[RD_LAT];
  assign m0_rdata   = ibus_rdata;
  assign m1_rdata   = ibus_rdata;

endmodule
